// File: rtl/key_debounce.sv
// key_debounce: push-button conditioning for the LED blink/pattern logic.
// Synchronises a raw key, filters contact bounce and produces single-cycle
// press / release / long-press events plus a wrapping 8-bit press counter.
// Optional auto-repeat is compiled in when the macro KEY_REPEAT_EN is defined;
// without it key_repeat is a constant 0.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int LONG_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000,
   parameter int KEY_ACTIVE_LOW  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_in,
   output logic       key_level,
   output logic       key_press,
   output logic       key_release,
   output logic       key_long,
   output logic       key_repeat,
   output logic [7:0] press_cnt
);

   localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
   localparam int HW   = (HMAX > 1) ? $clog2(HMAX) : 1;

   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_LONG = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HCNT_MAX  = '1;
   localparam logic          KEY_IDLE  = (KEY_ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      IDLE,
      FILTER_DN,
      DOWN,
      FILTER_UP
   } state_t;

   logic          sync1;
   logic          sync2;
   logic          pressed;
   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] dcnt;
   logic [DW-1:0] dcnt_nxt;
   logic [HW-1:0] hcnt;
   logic [HW-1:0] hcnt_nxt;
   logic          long_done;
   logic          long_done_nxt;
   logic          level_nxt;
   logic          press_nxt;
   logic          release_nxt;
   logic          long_nxt;
   logic [7:0]    cnt_nxt;

   assign pressed = sync2 ^ KEY_IDLE;

   // Two-flop synchroniser; reset parks both flops at the released key level
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= KEY_IDLE;
         sync2 <= KEY_IDLE;
      end else begin
         sync1 <= key_in;
         sync2 <= sync1;
      end
   end

   // Next-state, counter and event decode for the debounce FSM
   always_comb begin
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      hcnt_nxt      = hcnt;
      long_done_nxt = long_done;
      level_nxt     = key_level;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      cnt_nxt       = press_cnt;

      if (state == DOWN || state == FILTER_UP) begin
         if (hcnt != HCNT_MAX) begin
            hcnt_nxt = hcnt + HW'(1);
         end
         if (!long_done && hcnt == HCNT_LONG) begin
            long_nxt      = 1'b1;
            long_done_nxt = 1'b1;
         end
      end

      case (state)
         IDLE: begin
            level_nxt = 1'b0;
            if (pressed) begin
               state_nxt = FILTER_DN;
               dcnt_nxt  = '0;
            end
         end
         FILTER_DN: begin
            if (!pressed) begin
               state_nxt = IDLE;
            end else if (dcnt == DCNT_LAST) begin
               state_nxt     = DOWN;
               press_nxt     = 1'b1;
               level_nxt     = 1'b1;
               cnt_nxt       = press_cnt + 8'd1;
               hcnt_nxt      = '0;
               long_done_nxt = 1'b0;
            end else begin
               dcnt_nxt = dcnt + DW'(1);
            end
         end
         DOWN: begin
            if (!pressed) begin
               state_nxt = FILTER_UP;
               dcnt_nxt  = '0;
            end
         end
         FILTER_UP: begin
            if (pressed) begin
               state_nxt = DOWN;
            end else if (dcnt == DCNT_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               level_nxt   = 1'b0;
            end else begin
               dcnt_nxt = dcnt + DW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and registered event outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         dcnt        <= '0;
         hcnt        <= '0;
         long_done   <= 1'b0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         press_cnt   <= 8'd0;
      end else begin
         state       <= state_nxt;
         dcnt        <= dcnt_nxt;
         hcnt        <= hcnt_nxt;
         long_done   <= long_done_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_long    <= long_nxt;
         press_cnt   <= cnt_nxt;
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_nxt;
   logic          repeat_nxt;

   // Repeat interval runs only while stably held in DOWN after the long press;
   // the long-press edge and any return from a release bounce restart it
   always_comb begin
      rcnt_nxt   = rcnt;
      repeat_nxt = 1'b0;
      if (long_nxt) begin
         rcnt_nxt = '0;
      end else if (state == DOWN && pressed && long_done) begin
         if (rcnt == RCNT_LAST) begin
            repeat_nxt = 1'b1;
            rcnt_nxt   = '0;
         end else begin
            rcnt_nxt = rcnt + RW'(1);
         end
      end else begin
         rcnt_nxt = '0;
      end
   end

   // Repeat counter and registered repeat pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rcnt       <= '0;
         key_repeat <= 1'b0;
      end else begin
         rcnt       <= rcnt_nxt;
         key_repeat <= repeat_nxt;
      end
   end
`else
   assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed and randomized checks of key_debounce against a
// window-based reference model (a level change is accepted once the
// synchronised key has shown the new level for DEBOUNCE_CYCLES+1 edges).
module tb_key_debounce;

   localparam int D    = 8;
   localparam int L    = 40;
   localparam int R    = 10;
   localparam int MAXE = 16384;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_in;
   logic       key_level;
   logic       key_press;
   logic       key_release;
   logic       key_long;
   logic       key_repeat;
   logic [7:0] press_cnt;

   int checks = 0;
   int errors = 0;

   // Edge index of the most recent rising clock edge
   int n = -1;

   // Per-edge history: key as pressed-level captured by the first flop,
   // whether the edge was a reset edge, and pressed level seen by the FSM
   bit spA  [MAXE];
   bit rstA [MAXE];
   bit prA  [MAXE];

   bit       mLevel;
   bit [7:0] mCnt;
   bit       mLongArmed;
   bit       mLongFired;
   int       mPressEdge;
`ifdef KEY_REPEAT_EN
   int       mAnchor;
`endif

   logic       eLevel;
   logic       ePress;
   logic       eRelease;
   logic       eLong;
   logic       eRepeat;
   logic [7:0] eCnt;

   int obsPress   = 0;
   int obsRelease = 0;
   int obsLong    = 0;
   int obsRepeat  = 0;
   int lastPressEdge   = -1;
   int lastReleaseEdge = -1;
   int lastLongEdge    = -1;
   int firstRepEdge    = -1;

   always #5 clk = ~clk;

   key_debounce #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R),
      .KEY_ACTIVE_LOW  (1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long),
      .key_repeat  (key_repeat),
      .press_cnt   (press_cnt)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model for one rising edge with the given key_in / rst_n
   task automatic modelStep(input logic k, input logic r);
      bit acc;
      ePress   = 1'b0;
      eRelease = 1'b0;
      eLong    = 1'b0;
      eRepeat  = 1'b0;
      if (!r) begin
         spA[n]     = 1'b0;
         rstA[n]    = 1'b1;
         prA[n]     = 1'b0;
         mLevel     = 1'b0;
         mCnt       = 8'd0;
         mLongArmed = 1'b0;
         mLongFired = 1'b0;
`ifdef KEY_REPEAT_EN
         mAnchor    = -1;
`endif
         eLevel     = 1'b0;
         eCnt       = 8'd0;
         return;
      end
      spA[n]  = ~k;
      rstA[n] = 1'b0;
      if (n < 2 || rstA[n-1]) prA[n] = 1'b0;
      else                    prA[n] = spA[n-2];

      acc = (n >= D);
      for (int j = 0; j <= D; j++) begin
         if (n - j >= 0 && prA[n-j] == mLevel) acc = 1'b0;
      end

`ifdef KEY_REPEAT_EN
      if (mLongFired && mLevel) begin
         if (!prA[n]) mAnchor = -1;
         else if (mAnchor < 0) mAnchor = n;
         else if (n - mAnchor == R) begin
            eRepeat = 1'b1;
            mAnchor = n;
         end
      end
`endif

      if (mLongArmed && n - mPressEdge == L) begin
         eLong      = 1'b1;
         mLongArmed = 1'b0;
         mLongFired = 1'b1;
`ifdef KEY_REPEAT_EN
         mAnchor    = prA[n] ? n : -1;
`endif
      end

      if (acc) begin
         if (!mLevel) begin
            ePress     = 1'b1;
            mLevel     = 1'b1;
            mCnt       = mCnt + 8'd1;
            mPressEdge = n;
            mLongArmed = 1'b1;
            mLongFired = 1'b0;
`ifdef KEY_REPEAT_EN
            mAnchor    = -1;
`endif
         end else begin
            eRelease   = 1'b1;
            mLevel     = 1'b0;
            mLongArmed = 1'b0;
            mLongFired = 1'b0;
         end
      end
      eLevel = mLevel;
      eCnt   = mCnt;
   endtask

   // Drive one cycle, step the model at the edge and compare 1 ns later
   task automatic applyStimulus(input logic k, input logic r);
      key_in = k;
      rst_n  = r;
      @(posedge clk);
      n++;
      if (n >= MAXE) begin
         $display("[TB] FAIL edge_budget: observed=%0d expected<%0d", n, MAXE);
         $fatal(1, "[TB] edge budget exhausted");
      end
      modelStep(k, r);
      #1;
      checkOutput("key_level",   key_level,   eLevel);
      checkOutput("key_press",   key_press,   ePress);
      checkOutput("key_release", key_release, eRelease);
      checkOutput("key_long",    key_long,    eLong);
      checkOutput("key_repeat",  key_repeat,  eRepeat);
      checkOutput("press_cnt",   press_cnt,   eCnt);
      if (key_press === 1'b1)   begin obsPress++;   lastPressEdge   = n; end
      if (key_release === 1'b1) begin obsRelease++; lastReleaseEdge = n; end
      if (key_long === 1'b1)    begin obsLong++;    lastLongEdge    = n; end
      if (key_repeat === 1'b1) begin
         obsRepeat++;
         if (firstRepEdge < 0) firstRepEdge = n;
      end
      @(negedge clk);
   endtask

   task automatic holdKey(input logic k, input int cycles);
      for (int c = 0; c < cycles; c++) applyStimulus(k, 1'b1);
   endtask

   initial begin
      int s;
      int p0;
      int r0;
      int l0;
      int q0;
      int len;
      logic lvl;

      // Reset with the key released
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
      checkOutput("reset_level", key_level, 0);
      checkOutput("reset_cnt",   press_cnt, 0);
      holdKey(1'b1, 5);

      // Clean press: pulse after edge 11 counting the first low sample as 1
      s = n + 1; p0 = obsPress; l0 = obsLong;
      holdKey(1'b0, 30);
      checkOutput("clean_press_count", obsPress - p0, 1);
      checkOutput("clean_press_edge",  lastPressEdge - s + 1, D + 3);
      checkOutput("clean_no_long",     obsLong - l0, 0);
      checkOutput("clean_cnt",         press_cnt, 1);
      s = n + 1;
      holdKey(1'b1, 20);
      checkOutput("clean_release_edge", lastReleaseEdge - s + 1, D + 3);
      checkOutput("clean_level_low",    key_level, 0);

      // Press-side bounce restarts the filter from the final low sample
      holdKey(1'b0, 5);
      holdKey(1'b1, 1);
      s = n + 1; p0 = obsPress;
      holdKey(1'b0, 20);
      checkOutput("bounce_press_count", obsPress - p0, 1);
      checkOutput("bounce_press_edge",  lastPressEdge - s + 1, D + 3);

      // Release-side glitch while held produces no release
      r0 = obsRelease;
      holdKey(1'b1, 1);
      holdKey(1'b0, 15);
      checkOutput("glitch_no_release", obsRelease - r0, 0);
      checkOutput("glitch_level_held", key_level, 1);
      holdKey(1'b1, 20);

      // Long press: key_long once, 50 edges after the first low sample
      s = n + 1; l0 = obsLong;
      holdKey(1'b0, 70);
      checkOutput("long_count", obsLong - l0, 1);
      checkOutput("long_edge",  lastLongEdge - s + 1, D + 3 + L);
      s = n + 1;
      holdKey(1'b1, 20);
      checkOutput("long_release_edge", lastReleaseEdge - s + 1, D + 3);
      checkOutput("long_level_low",    key_level, 0);

      // Mid-cycle reset with the key held: outputs hold until the next edge
      holdKey(1'b0, 20);
      rst_n = 1'b0;
      #2;
      checkOutput("midcycle_level", key_level, eLevel);
      checkOutput("midcycle_cnt",   press_cnt, eCnt);
      r0 = obsRelease;
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("reset_held_level",      key_level, 0);
      checkOutput("reset_held_no_release", obsRelease - r0, 0);
      s = n + 1; p0 = obsPress;
      holdKey(1'b0, 20);
      checkOutput("fresh_press_count", obsPress - p0, 1);
      checkOutput("fresh_press_edge",  lastPressEdge - s + 1, D + 3);
      holdKey(1'b1, 20);

      // Wrap: 256 presses from a cleared counter return press_cnt to 0
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      p0 = obsPress;
      for (int i = 0; i < 256; i++) begin
         holdKey(1'b0, 12);
         holdKey(1'b1, 12);
      end
      checkOutput("wrap_press_count", obsPress - p0, 256);
      checkOutput("wrap_cnt",         press_cnt, 0);

      // Auto-repeat during an 85-cycle hold, silence during release
      s = n + 1; q0 = obsRepeat; firstRepEdge = -1;
      holdKey(1'b0, 85);
`ifdef KEY_REPEAT_EN
      checkOutput("repeat_count",      obsRepeat - q0, 3);
      checkOutput("repeat_first_edge", firstRepEdge - s + 1, D + 3 + L + R);
`else
      checkOutput("repeat_absent", obsRepeat - q0, 0);
`endif
      q0 = obsRepeat;
      holdKey(1'b1, 20);
      checkOutput("repeat_stops_on_release", obsRepeat - q0, 0);

      // Randomized runs of key levels with occasional resets
      for (int i = 0; i < 300; i++) begin
         lvl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) len = int'($urandom_range(20, 60));
         else                           len = int'($urandom_range(1, 12));
         if ($urandom_range(0, 39) == 0) applyStimulus(lvl, 1'b0);
         holdKey(lvl, len);
      end
      holdKey(1'b1, 20);

      $display("[TB] done after %0d edges", n + 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
